alu_flags_reg: RTL and testbench
================================

Name: alu_flags_reg

Overview:
- Parametrised, registered successor to the combinational ALU overflow flag.
- Computes the N, Z, C and V flags for add, subtract and logic results of any width N, and latches them into a status register on a write-enable.
- Also keeps a sticky overflow bit and a saturating overflow event counter.
- Sits between the ALU datapath and the condition-check and branch logic of the processor.

Parameters:
- N, default 32: operand and result width in bits; N ≥ 2.
- CNT_W, default 8: width of the overflow event counter; CNT_W ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- AluControl_in  input  2  operation: 00 ADD, 01 SUB (a−b), 10 AND, 11 OR.
- a_i  input  N  operand A.
- b_i  input  N  operand B, un-inverted (as presented to the ALU).
- Sum  input  N  ALU result for the current operation.
- carry_i  input  1  adder carry-out. For SUB this is the carry of a+~b+1, so 1 = no borrow.
- flag_we  input  1  latch the computed flags this cycle.
- sticky_clr  input  1  clear the sticky overflow bit and the counter.
- flags_o  output  4  registered {N,Z,C,V}.
- v_sticky_o  output  1  set by any latched overflow; held until cleared.
- ovf_count_o  output  CNT_W  number of latched overflows, saturating.
- flags_valid_o  output  1  one-cycle pulse: flags_o updated this cycle.

Behaviour:
- Reset (rst=1 at a rising edge): flags_o=0, v_sticky_o=0, ovf_count_o=0, flags_valid_o=0.
  - rst has priority over flag_we and sticky_clr.
  - Mid-operation reset discards any pending update; nothing latched that cycle survives.
- Combinational next-flag computation, from the current-cycle inputs:
  - Nn = Sum[N-1]
  - Zn = (Sum == 0)
  - ADD: Cn = carry_i; Vn = ~(a_i[N-1]^b_i[N-1]) & (a_i[N-1]^Sum[N-1])
  - SUB: Cn = carry_i; Vn = (a_i[N-1]^b_i[N-1]) & (a_i[N-1]^Sum[N-1])
  - AND/OR: Cn = 0, Vn = 0; N and Z are still computed from Sum.
- Latency: flags_o reflects the inputs sampled at the edge where flag_we=1. It is visible the following cycle, which is also when flags_valid_o=1.
- flag_we=0: flags_o holds its value; flags_valid_o=0 on the next cycle.
- Back-to-back flag_we: each cycle latches a new value and flags_valid_o stays high continuously.
- Sticky bit and counter, per cycle, in priority order:
  - rst.
  - Otherwise: base = sticky_clr ? 0 : current value.
  - v_sticky_next = base_sticky | (flag_we & Vn).
  - ovf_count_next = base_count + (flag_we & Vn), saturating at 2^CNT_W−1. It never wraps to 0.
- Simultaneous sticky_clr and latched overflow: the result is v_sticky_o=1 and ovf_count_o=1. The clear applies first, then the new event is counted.
- sticky_clr never affects flags_o.
- X on AluControl_in while flag_we=0 has no effect on state.
- Implementation: a single always_ff for the registers, with the flag computation in always_comb or assigns. There are no latches.

Test Plan:
- N=8, reset then ADD a=0x7F, b=0x01, Sum=0x80, carry_i=0, flag_we=1 -> next cycle flags_o=1001 (N=1,Z=0,C=0,V=1), flags_valid_o=1, v_sticky_o=1, ovf_count_o=1.
- N=8, SUB a=0x80, b=0x01, Sum=0x7F, carry_i=1, we=1 -> flags_o=0011. Then SUB a=0x05, b=0x05, Sum=0x00, carry_i=1 -> flags_o=0110; v_sticky_o stays 1.
- N=8, AND a=0xF0, b=0x0F, Sum=0x00, carry_i=1, we=1 -> flags_o=0100. C and V are forced to 0 despite carry_i=1.
- CNT_W=2, four consecutive overflowing ADDs with we=1 -> ovf_count_o goes 1, 2, 3, 3 (saturates). Then sticky_clr alone -> count=0, sticky=0, flags_o unchanged.
- Overflowing ADD with we=1 and sticky_clr=1 in the same cycle -> v_sticky_o=1, ovf_count_o=1. Same stimulus with we=0 -> flags_o unchanged, flags_valid_o=0, sticky and count = 0.
- Assert rst in the same cycle as an overflowing flag_we -> next cycle all outputs 0. Deassert rst with flag_we=0 -> outputs remain 0.

Source files
------------

// File: rtl/alu_flags_reg.sv
// Registered ALU status flags {N,Z,C,V} with a sticky overflow bit and a
// saturating overflow event counter, parametrised on datapath width.
module alu_flags_reg #(
   parameter int N     = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       AluControl_in,
   input  logic [N-1:0]     a_i,
   input  logic [N-1:0]     b_i,
   input  logic [N-1:0]     Sum,
   input  logic             carry_i,
   input  logic             flag_we,
   input  logic             sticky_clr,
   output logic [3:0]       flags_o,
   output logic             v_sticky_o,
   output logic [CNT_W-1:0] ovf_count_o,
   output logic             flags_valid_o
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_e;

   logic             sign_a, sign_b, sign_s;
   logic             n_flag, z_flag, c_flag, v_flag;
   logic             ovf_evt;
   logic             sticky_base;
   logic [CNT_W-1:0] count_base;

   logic [3:0]       flags_d, flags_q;
   logic             v_sticky_d, v_sticky_q;
   logic [CNT_W-1:0] ovf_count_d, ovf_count_q;
   logic             flags_valid_d, flags_valid_q;

   // Only the sign bits of the operands matter for overflow detection.
   logic             unused_operand_bits;
   assign unused_operand_bits = ^{a_i[N-2:0], b_i[N-2:0]};

   always_comb begin
      sign_a = a_i[N-1];
      sign_b = b_i[N-1];
      sign_s = Sum[N-1];
      n_flag = sign_s;
      z_flag = (Sum == '0);
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (alu_op_e'(AluControl_in))
         OP_ADD: begin
            c_flag = carry_i;
            v_flag = ~(sign_a ^ sign_b) & (sign_a ^ sign_s);
         end
         OP_SUB: begin
            c_flag = carry_i;
            v_flag = (sign_a ^ sign_b) & (sign_a ^ sign_s);
         end
         default: begin
            c_flag = 1'b0;
            v_flag = 1'b0;
         end
      endcase
   end

   always_comb begin
      flags_d       = flags_q;
      flags_valid_d = 1'b0;
      ovf_evt       = 1'b0;
      if (flag_we) begin
         flags_d       = {n_flag, z_flag, c_flag, v_flag};
         flags_valid_d = 1'b1;
         ovf_evt       = v_flag;
      end
      // Clear is applied before the new event, so clear+overflow yields 1.
      sticky_base = sticky_clr ? 1'b0 : v_sticky_q;
      count_base  = sticky_clr ? '0   : ovf_count_q;
      v_sticky_d  = sticky_base | ovf_evt;
      if (ovf_evt && (count_base != '1)) begin
         ovf_count_d = count_base + CNT_W'(1);
      end else begin
         ovf_count_d = count_base;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q       <= '0;
         v_sticky_q    <= 1'b0;
         ovf_count_q   <= '0;
         flags_valid_q <= 1'b0;
      end else begin
         flags_q       <= flags_d;
         v_sticky_q    <= v_sticky_d;
         ovf_count_q   <= ovf_count_d;
         flags_valid_q <= flags_valid_d;
      end
   end

   assign flags_o       = flags_q;
   assign v_sticky_o    = v_sticky_q;
   assign ovf_count_o   = ovf_count_q;
   assign flags_valid_o = flags_valid_q;

endmodule

// File: tb/tb_alu_flags_reg.sv
// Scoreboard bench for alu_flags_reg (N=8, CNT_W=2): directed vectors push
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_alu_flags_reg;

   localparam int N     = 8;
   localparam int CNT_W = 2;

   typedef struct packed {
      logic [15:0]      id;
      logic [3:0]       flags;
      logic             valid;
      logic             sticky;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [1:0]       alu_ctl;
   logic [N-1:0]     a, b, s;
   logic             carry;
   logic             we;
   logic             clr;
   logic [3:0]       flags;
   logic             sticky;
   logic [CNT_W-1:0] cnt;
   logic             valid;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   step_id;
   logic done;

   alu_flags_reg #(.N(N), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .AluControl_in (alu_ctl),
      .a_i           (a),
      .b_i           (b),
      .Sum           (s),
      .carry_i       (carry),
      .flag_we       (we),
      .sticky_clr    (clr),
      .flags_o       (flags),
      .v_sticky_o    (sticky),
      .ovf_count_o   (cnt),
      .flags_valid_o (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] id,
                      input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s step %0d: got %b expected %b", name, id, got, want);
      end
   endtask

   // Monitor: every cycle the registered outputs are compared to the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("flags", e.id, flags, e.flags);
         chk("valid", e.id, {3'b0, valid}, {3'b0, e.valid});
         chk("sticky", e.id, {3'b0, sticky}, {3'b0, e.sticky});
         chk("count", e.id, {2'b0, cnt}, {2'b0, e.cnt});
      end
   end

   task automatic cyc(input logic r, input logic [1:0] op,
                      input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vs,
                      input logic c, input logic w, input logic cl,
                      input logic [3:0] ef, input logic ev, input logic es,
                      input logic [CNT_W-1:0] ec);
      exp_t e;
      rst     = r;
      alu_ctl = op;
      a       = va;
      b       = vb;
      s       = vs;
      carry   = c;
      we      = w;
      clr     = cl;
      @(posedge clk);
      step_id++;
      e.id     = 16'(step_id);
      e.flags  = ef;
      e.valid  = ev;
      e.sticky = es;
      e.cnt    = ec;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      step_id = 0;
      done    = 1'b0;
      rst = 1'b1; alu_ctl = 2'b00; a = '0; b = '0; s = '0;
      carry = 1'b0; we = 1'b0; clr = 1'b0;
      @(negedge clk);

      //   rst op     a      b      Sum    c  we clr  flags   vld stk cnt
      cyc(1, 2'b00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 2'd0);
      cyc(0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 2'd0);
      // ADD overflow, SUB overflow, SUB zero, AND forces C/V, OR negative
      cyc(0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 4'b1001, 1, 1, 2'd1);
      cyc(0, 2'b01, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 4'b0011, 1, 1, 2'd2);
      cyc(0, 2'b01, 8'h05, 8'h05, 8'h00, 1, 1, 0, 4'b0110, 1, 1, 2'd2);
      cyc(0, 2'b10, 8'hF0, 8'h0F, 8'h00, 1, 1, 0, 4'b0100, 1, 1, 2'd2);
      cyc(0, 2'b11, 8'h80, 8'h01, 8'h81, 1, 1, 0, 4'b1000, 1, 1, 2'd2);
      // hold with we=0, even with an overflowing operand set present
      cyc(0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 0, 0, 4'b1000, 0, 1, 2'd2);
      // saturation at 3
      cyc(0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 4'b1001, 1, 1, 2'd3);
      cyc(0, 2'b00, 8'h80, 8'h80, 8'h00, 1, 1, 0, 4'b0111, 1, 1, 2'd3);
      cyc(0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 4'b0111, 0, 0, 2'd0);
      // four overflowing ADDs: 1,2,3,3
      cyc(0, 2'b00, 8'h40, 8'h40, 8'h80, 0, 1, 0, 4'b1001, 1, 1, 2'd1);
      cyc(0, 2'b00, 8'h7F, 8'h7F, 8'hFE, 0, 1, 0, 4'b1001, 1, 1, 2'd2);
      cyc(0, 2'b00, 8'h80, 8'hFF, 8'h7F, 1, 1, 0, 4'b0011, 1, 1, 2'd3);
      cyc(0, 2'b00, 8'h80, 8'h80, 8'h00, 1, 1, 0, 4'b0111, 1, 1, 2'd3);
      cyc(0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 4'b0111, 0, 0, 2'd0);
      // clear + overflow in same cycle -> sticky=1, count=1
      cyc(0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 4'b1001, 1, 1, 2'd1);
      cyc(0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 4'b1001, 1, 1, 2'd2);
      cyc(0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 1, 1, 4'b1001, 1, 1, 2'd1);
      cyc(0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 4'b1001, 0, 0, 2'd0);
      // no-overflow ADD, SUB with borrow, OR zero
      cyc(0, 2'b00, 8'h01, 8'h02, 8'h03, 0, 1, 0, 4'b0000, 1, 0, 2'd0);
      cyc(0, 2'b01, 8'h01, 8'h02, 8'hFF, 0, 1, 0, 4'b1000, 1, 0, 2'd0);
      cyc(0, 2'b11, 8'h00, 8'h00, 8'h00, 1, 1, 0, 4'b0100, 1, 0, 2'd0);
      // reset wins over an overflowing write, then stays clear
      cyc(0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 4'b1001, 1, 1, 2'd1);
      cyc(1, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 1, 1, 4'b0000, 0, 0, 2'd0);
      cyc(0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 0, 0, 4'b0000, 0, 0, 2'd0);

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
      end
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL timeout: got no completion expected completion");
         $fatal(1, "timeout");
      end
   end

endmodule
